// File: rtl/regfile_dual_issue.sv
// Multi-ported integer register file with same-cycle write bypass and a
// per-register busy scoreboard for in-order dual issue.
module regfile_dual_issue #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 4,
    parameter int NWR  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [NWR-1:0]      iss_en,
    input  logic [NWR*AW-1:0]   iss_rd,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Read ports: ascending scan over write ports lets the youngest writer win the bypass.
    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;
        logic            hit;
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra  = rs[i*AW +: AW];
            rv  = regs_q[ra];
            hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] == ra)) begin
                    rv  = wd[j*XLEN +: XLEN];
                    hit = 1'b1;
                end
            end
            if (ra == '0) begin
                rdata[i*XLEN +: XLEN] = '0;
                rbusy[i]              = 1'b0;
            end else begin
                rdata[i*XLEN +: XLEN] = rv;
                rbusy[i]              = busy_q[ra] & ~hit;
            end
        end
    end

    // Next state: writes clear busy, then issues set it so a new producer wins.
    always_comb begin
        logic [AW-1:0] a;
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            a = wa[j*AW +: AW];
            if (we[j] && (a != '0)) begin
                regs_d[a] = wd[j*XLEN +: XLEN];
                busy_d[a] = 1'b0;
            end
        end
        for (int k = 0; k < NWR; k++) begin
            a = iss_rd[k*AW +: AW];
            if (iss_en[k] && (a != '0)) begin
                busy_d[a] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_dual_issue.sv
// Scoreboard bench for regfile_dual_issue: a reference model predicts every
// read port and the busy vector each cycle, plus directed scenario checks.
module tb_regfile_dual_issue;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rs;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;
    logic [NWR-1:0]      iss_en;
    logic [NWR*AW-1:0]   iss_rd;
    logic [NREG-1:0]     busy_vec;

    regfile_dual_issue #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rdata(rdata), .rbusy(rbusy),
        .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_rd(iss_rd),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] v;
    } exp_t;

    exp_t            exp_q [$];
    logic [XLEN-1:0] m_reg [NREG];
    logic [NREG-1:0] m_busy;
    int              n_chk = 0;
    int              n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we     = '0;
        wa     = '0;
        wd     = '0;
        iss_en = '0;
        iss_rd = '0;
        rs     = '0;
        rst    = 1'b1;
    endtask

    // One clock: predict outputs from the model, compare, then advance the model.
    task automatic step(input bit chk);
        logic [XLEN-1:0] nreg [NREG];
        logic [NREG-1:0] nbusy;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] ed;
        logic            hit;
        exp_t            e;
        #1;
        if (chk) begin
            for (int i = 0; i < NRD; i++) begin
                a   = rs[i*AW +: AW];
                ed  = (a == 0) ? '0 : m_reg[a];
                hit = 1'b0;
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && wa[j*AW +: AW] == a && a != 0) begin
                        ed  = wd[j*XLEN +: XLEN];
                        hit = 1'b1;
                    end
                end
                exp_q.push_back('{$sformatf("rdata%0d", i), {32'h0, ed}});
                exp_q.push_back('{$sformatf("rbusy%0d", i),
                                  {63'h0, (a != 0) && m_busy[a] && !hit}});
            end
            exp_q.push_back('{"busy_vec", {32'h0, m_busy}});
            for (int i = 0; i < NRD; i++) begin
                for (int f = 0; f < 2; f++) begin
                    if (exp_q.size() == 0) begin
                        check("queue_underflow", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        if (f == 0) check(e.tag, {32'h0, rdata[i*XLEN +: XLEN]}, e.v);
                        else        check(e.tag, {63'h0, rbusy[i]}, e.v);
                    end
                end
            end
            if (exp_q.size() == 0) begin
                check("queue_underflow", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check(e.tag, {32'h0, busy_vec}, e.v);
            end
        end
        nreg  = m_reg;
        nbusy = m_busy;
        if (!rst) begin
            for (int r = 0; r < NREG; r++) nreg[r] = '0;
            nbusy = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                a = wa[j*AW +: AW];
                if (we[j] && a != 0) begin
                    nreg[a]  = wd[j*XLEN +: XLEN];
                    nbusy[a] = 1'b0;
                end
            end
            for (int k = 0; k < NWR; k++) begin
                a = iss_rd[k*AW +: AW];
                if (iss_en[k] && a != 0) nbusy[a] = 1'b1;
            end
        end
        @(posedge clk);
        m_reg  = nreg;
        m_busy = nbusy;
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) m_reg[r] = '0;
        m_busy = '0;
        idle();
        rst = 1'b0;
        step(1'b0);
        step(1'b1);
        idle();
        #1;
        check("reset_busy_vec", {32'h0, busy_vec}, 64'h0);
        check("reset_rdata", {32'h0, rdata[31:0]}, 64'h0);

        // Write x5 then read it back on port 0
        we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'hDEADBEEF;
        step(1'b1);
        idle(); rs[4:0] = 5'd5;
        #1;
        check("x5_read", {32'h0, rdata[31:0]}, 64'hDEADBEEF);
        check("x5_other", {32'h0, rdata[63:32]}, 64'h0);
        step(1'b1);

        // Dual write to x7: younger port wins, visible through bypass
        idle(); we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h2222, 32'h1111}; rs[9:5] = 5'd7;
        #1;
        check("x7_bypass", {32'h0, rdata[63:32]}, 64'h2222);
        step(1'b1);
        idle(); rs[9:5] = 5'd7;
        #1;
        check("x7_stored", {32'h0, rdata[63:32]}, 64'h2222);
        step(1'b1);

        // x0 is immune to writes and issues
        idle(); we = 2'b01; wd[31:0] = 32'hFFFFFFFF; iss_en = 2'b01;
        step(1'b1);
        idle();
        #1;
        check("x0_data", {32'h0, rdata[31:0]}, 64'h0);
        check("x0_busy", {63'h0, busy_vec[0]}, 64'h0);
        step(1'b1);

        // Issue x3, then its producer writes back
        idle(); iss_en = 2'b01; iss_rd[4:0] = 5'd3; rs[14:10] = 5'd3;
        #1;
        check("x3_rbusy_issue_cycle", {63'h0, rbusy[2]}, 64'h0);
        step(1'b1);
        idle(); rs[14:10] = 5'd3;
        #1;
        check("x3_busy_vec", {63'h0, busy_vec[3]}, 64'h1);
        check("x3_rbusy", {63'h0, rbusy[2]}, 64'h1);
        step(1'b1);
        idle(); rs[14:10] = 5'd3; we = 2'b01; wa[4:0] = 5'd3; wd[31:0] = 32'h55;
        #1;
        check("x3_wb_rbusy", {63'h0, rbusy[2]}, 64'h0);
        check("x3_wb_rdata", {32'h0, rdata[95:64]}, 64'h55);
        step(1'b1);
        idle(); rs[14:10] = 5'd3;
        #1;
        check("x3_cleared", {63'h0, busy_vec[3]}, 64'h0);
        step(1'b1);

        // Issue and write to x9 together: data lands, busy stays set
        idle(); iss_en = 2'b10; iss_rd[9:5] = 5'd9; we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'hAB;
        step(1'b1);
        idle(); rs[19:15] = 5'd9;
        #1;
        check("x9_data", {32'h0, rdata[127:96]}, 64'hAB);
        check("x9_busy_vec", {63'h0, busy_vec[9]}, 64'h1);
        check("x9_rbusy", {63'h0, rbusy[3]}, 64'h1);
        step(1'b1);

        // Randomised traffic with occasional reset pulses
        for (int c = 0; c < 300; c++) begin
            idle();
            rst    = ($urandom_range(0, 29) != 0);
            we     = 2'($urandom);
            wa     = 10'($urandom);
            wd     = {$urandom, $urandom};
            iss_en = 2'($urandom);
            iss_rd = 10'($urandom);
            rs     = 20'($urandom);
            if ($urandom_range(0, 3) == 0) wa[9:5] = wa[4:0];
            if ($urandom_range(0, 3) == 0) rs[4:0] = wa[4:0];
            if ($urandom_range(0, 3) == 0) iss_rd[4:0] = wa[9:5];
            step(1'b1);
        end

        // Fill every register and mark it busy, then reset
        idle();
        for (int r = 1; r < NREG; r += 2) begin
            idle();
            we = 2'b11;
            wa = {5'(r + 1), 5'(r)};
            wd = {32'hA000_0000 + 32'(r + 1), 32'hA000_0000 + 32'(r)};
            if (r + 1 >= NREG) we = 2'b01;
            step(1'b1);
            idle();
            iss_en = 2'b11;
            iss_rd = {5'(r + 1), 5'(r)};
            step(1'b1);
        end
        idle(); rs = {5'd31, 5'd17, 5'd2, 5'd1};
        #1;
        check("filled_x1", {32'h0, rdata[31:0]}, 64'hA0000001);
        check("filled_busy", {32'h0, busy_vec}, 64'hFFFFFFFE);
        rst = 1'b0;
        step(1'b1);
        for (int r = 0; r < NREG; r += NRD) begin
            idle();
            rs = {5'(r + 3), 5'(r + 2), 5'(r + 1), 5'(r)};
            #1;
            check("post_rst_rdata", {rdata[127:96] | rdata[95:64], rdata[63:32] | rdata[31:0]}, 64'h0);
            check("post_rst_rbusy", {60'h0, rbusy}, 64'h0);
            step(1'b1);
        end
        check("post_rst_busy_vec", {32'h0, busy_vec}, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
